// File: rtl/i2s_timing_ctrl_pkg.sv
// Shared types and constants for the I2S master timing sequencer.
package i2s_timing_ctrl_pkg;

  localparam int CNT_W  = 6;
  localparam int IDX_W  = 5;
  localparam int WORD16 = 16;
  localparam int WORD32 = 32;

  typedef enum logic {
    f16bits,
    f32bits
  } frame_size_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } ctrl_state_t;

  function automatic int word_len(frame_size_t f);
    return (f == f32bits) ? WORD32 : WORD16;
  endfunction

endpackage

// File: rtl/i2s_timing_ctrl_if.sv
// Configuration handshake between the control-register block and the sequencer.
interface i2s_timing_ctrl_if
  import i2s_timing_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_half;
  frame_size_t      cfg_frame;

  modport master (output cfg_valid, cfg_half, cfg_frame, input cfg_ready);
  modport slave  (input cfg_valid, cfg_half, cfg_frame, output cfg_ready);

endinterface

// File: rtl/i2s_timing_ctrl_sclk_tick.sv
// Half-period counter producing a registered sclk level plus rise/fall strobes.
module i2s_timing_ctrl_sclk_tick #(
  parameter int CNT_W = 6
) (
  input  logic             pclk,
  input  logic             rst_,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_half,
  output logic             o_sclk,
  output logic             o_sclk_rise,
  output logic             o_sclk_fall,
  output logic             o_fall_next
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             r_rise;
  logic             r_fall;
  logic             w_wrap;

  assign w_wrap      = i_run && (r_cnt == (i_half - CNT_W'(1)));
  // Lets the parent update word state on the same edge that sclk falls.
  assign o_fall_next = w_wrap && r_sclk;

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (!i_run) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
      r_rise <= ~r_sclk;
      r_fall <= r_sclk;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  assign o_sclk      = r_sclk;
  assign o_sclk_rise = r_rise;
  assign o_sclk_fall = r_fall;

endmodule

// File: rtl/i2s_timing_ctrl.sv
// I2S master timing sequencer: config shadow, run/drain FSM, word select and bit index.
module i2s_timing_ctrl
  import i2s_timing_ctrl_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int IDX_W = 5
) (
  input  logic             pclk,
  input  logic             rst_,
  i2s_timing_ctrl_if.slave cfg,
  input  logic             i_start,
  input  logic             i_stop,
  output logic             o_busy,
  output logic             o_sclk,
  output logic             o_sclk_rise,
  output logic             o_sclk_fall,
  output logic             o_ws,
  output logic             o_ws_change,
  output logic             o_frame_start,
  output logic [IDX_W-1:0] o_bit_idx,
  output logic             o_cfg_err
);

  ctrl_state_t      r_state;
  logic [CNT_W-1:0] r_half;
  frame_size_t      r_frame;
  logic             r_loaded;
  logic             r_cfg_ready;
  logic             r_busy;
  logic             r_ws;
  logic             r_ws_change;
  logic             r_frame_start;
  logic [IDX_W-1:0] r_bit_idx;
  logic             r_cfg_err;

  logic             w_hs;
  logic             w_cfg_ok;
  logic             w_last;
  logic             w_fall_next;
  logic             w_run;

  assign w_hs     = cfg.cfg_valid && (r_state == IDLE);
  assign w_cfg_ok = w_hs && (cfg.cfg_half != '0);
  assign w_last   = (r_bit_idx == IDX_W'(word_len(r_frame) - 1));
  assign w_run    = (r_state != IDLE);

  i2s_timing_ctrl_sclk_tick #(.CNT_W(CNT_W)) u_tick (
    .pclk        (pclk),
    .rst_        (rst_),
    .i_run       (w_run),
    .i_half      (r_half),
    .o_sclk      (o_sclk),
    .o_sclk_rise (o_sclk_rise),
    .o_sclk_fall (o_sclk_fall),
    .o_fall_next (w_fall_next)
  );

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      r_state       <= IDLE;
      r_half        <= '0;
      r_frame       <= f16bits;
      r_loaded      <= 1'b0;
      r_cfg_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_ws          <= 1'b1;
      r_ws_change   <= 1'b0;
      r_frame_start <= 1'b0;
      r_bit_idx     <= '0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_ws_change   <= 1'b0;
      r_frame_start <= 1'b0;
      r_cfg_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cfg_ok) begin
            r_half   <= cfg.cfg_half;
            r_frame  <= cfg.cfg_frame;
            r_loaded <= 1'b1;
          end
          if (w_hs && !w_cfg_ok) r_cfg_err <= 1'b1;
          if (i_start && !i_stop) begin
            if (r_loaded || w_cfg_ok) begin
              r_state       <= RUN;
              r_busy        <= 1'b1;
              r_cfg_ready   <= 1'b0;
              r_ws          <= 1'b0;
              r_bit_idx     <= '0;
              r_ws_change   <= 1'b1;
              r_frame_start <= 1'b1;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        default: begin
          if (r_state == RUN && i_stop) r_state <= DRAIN;
          if (w_fall_next) begin
            if (!w_last) begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end else if (r_ws && r_state == DRAIN) begin
              // Right word done while draining: park silently instead of opening a new frame.
              r_state     <= IDLE;
              r_busy      <= 1'b0;
              r_cfg_ready <= 1'b1;
              r_bit_idx   <= '0;
            end else begin
              r_bit_idx     <= '0;
              r_ws          <= ~r_ws;
              r_ws_change   <= 1'b1;
              r_frame_start <= r_ws;
            end
          end
        end
      endcase
    end
  end

  assign cfg.cfg_ready  = r_cfg_ready;
  assign o_busy         = r_busy;
  assign o_ws           = r_ws;
  assign o_ws_change    = r_ws_change;
  assign o_frame_start  = r_frame_start;
  assign o_bit_idx      = r_bit_idx;
  assign o_cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_i2s_timing_ctrl.sv
// Self-checking bench: expected strobe times are queued when a run is started and popped as the DUT emits them.
module tb_i2s_timing_ctrl;
  import i2s_timing_ctrl_pkg::*;

  logic       pclk = 1'b0;
  logic       rst_ = 1'b1;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       o_busy, o_sclk, o_sclk_rise, o_sclk_fall;
  logic       o_ws, o_ws_change, o_frame_start, o_cfg_err;
  logic [4:0] o_bit_idx;

  i2s_timing_ctrl_if #(.CNT_W(6)) u_if ();

  i2s_timing_ctrl #(.CNT_W(6), .IDX_W(5)) dut (
    .pclk          (pclk),
    .rst_          (rst_),
    .cfg           (u_if),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .o_busy        (o_busy),
    .o_sclk        (o_sclk),
    .o_sclk_rise   (o_sclk_rise),
    .o_sclk_fall   (o_sclk_fall),
    .o_ws          (o_ws),
    .o_ws_change   (o_ws_change),
    .o_frame_start (o_frame_start),
    .o_bit_idx     (o_bit_idx),
    .o_cfg_err     (o_cfg_err)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         c;
    logic [4:0] b;
    logic       w;
  } fall_t;

  int    q_rise[$];
  int    q_wsc[$];
  int    q_fs[$];
  fall_t q_fall[$];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    i_start = 1'b0;
    i_stop = 1'b0;
    u_if.cfg_valid = 1'b0;
    tick();
    tick();
    rst_ = 1'b1;
  endtask

  task automatic load_cfg(input int h, input frame_size_t f);
    u_if.cfg_valid = 1'b1;
    u_if.cfg_half  = 6'(h);
    u_if.cfg_frame = f;
    tick();
    u_if.cfg_valid = 1'b0;
  endtask

  // Expected strobes for a run entered at cycle e: fall n at e+2nh, rise n at e+(2n-1)h.
  task automatic plan_stream(input int e, input int h, input int w, input int exit_n, input int endc);
    fall_t fe;
    q_wsc.push_back(e);
    q_fs.push_back(e);
    for (int n = 1; n < 4096; n++) begin
      if (e + (2 * n - 1) * h >= endc) break;
      q_rise.push_back(e + (2 * n - 1) * h);
      if (e + 2 * n * h < endc) begin
        fe.c = e + 2 * n * h;
        if (exit_n != 0 && n == exit_n) begin
          fe.b = 5'd0;
          fe.w = 1'b1;
          q_fall.push_back(fe);
          break;
        end
        fe.b = 5'(n % w);
        fe.w = 1'((n / w) % 2);
        q_fall.push_back(fe);
        if (n % w == 0) q_wsc.push_back(fe.c);
        if (n % (2 * w) == 0) q_fs.push_back(fe.c);
      end
    end
  endtask

  task automatic test_reset_values();
    n_vec++;
    if (o_busy !== 1'b0 || o_sclk !== 1'b0 || o_ws !== 1'b1 || o_bit_idx !== 5'd0 ||
        u_if.cfg_ready !== 1'b1 || o_sclk_rise !== 1'b0 || o_sclk_fall !== 1'b0 ||
        o_ws_change !== 1'b0 || o_frame_start !== 1'b0 || o_cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: busy=%b sclk=%b ws=%b idx=%0d rdy=%b pulses=%b%b%b%b err=%b want 0 0 1 0 1 0000 0",
               o_busy, o_sclk, o_ws, o_bit_idx, u_if.cfg_ready, o_sclk_rise, o_sclk_fall,
               o_ws_change, o_frame_start, o_cfg_err);
    end
    $display("reset_values: busy=%b sclk=%b ws=%b rdy=%b", o_busy, o_sclk, o_ws, u_if.cfg_ready);
  endtask

  task automatic test_stream(input string name, input int h, input frame_size_t f,
                             input int len, input bit stop_mode);
    int    w, x, e, c, t_exit;
    bit    stopped, er, ef, ew, es;
    fall_t fe;
    w = (f == f32bits) ? WORD32 : WORD16;
    x = stop_mode ? 2 * w : 0;
    q_rise.delete(); q_fall.delete(); q_wsc.delete(); q_fs.delete();
    load_cfg(h, f);
    i_start = 1'b1;
    e = cyc + 1;
    t_exit = e + 2 * h * x;
    plan_stream(e, h, w, x, e + len);
    stopped = 1'b0;
    for (int k = 0; k < len; k++) begin
      tick();
      i_start = 1'b0;
      i_stop = 1'b0;
      c = cyc;
      er = (q_rise.size() > 0) && (q_rise[0] == c);
      n_vec++;
      if (o_sclk_rise !== er) begin
        n_bad++;
        $display("FAIL %s rise @+%0d: got %b want %b", name, c - e, o_sclk_rise, er);
      end
      if (er) void'(q_rise.pop_front());
      ef = (q_fall.size() > 0) && (q_fall[0].c == c);
      n_vec++;
      if (o_sclk_fall !== ef) begin
        n_bad++;
        $display("FAIL %s fall @+%0d: got %b want %b", name, c - e, o_sclk_fall, ef);
      end
      if (ef) begin
        fe = q_fall.pop_front();
        n_vec++;
        if (o_bit_idx !== fe.b || o_ws !== fe.w) begin
          n_bad++;
          $display("FAIL %s idx/ws @+%0d: got %0d/%b want %0d/%b", name, c - e, o_bit_idx, o_ws, fe.b, fe.w);
        end
      end
      ew = (q_wsc.size() > 0) && (q_wsc[0] == c);
      n_vec++;
      if (o_ws_change !== ew) begin
        n_bad++;
        $display("FAIL %s ws_change @+%0d: got %b want %b", name, c - e, o_ws_change, ew);
      end
      if (ew) void'(q_wsc.pop_front());
      es = (q_fs.size() > 0) && (q_fs[0] == c);
      n_vec++;
      if (o_frame_start !== es) begin
        n_bad++;
        $display("FAIL %s frame_start @+%0d: got %b want %b", name, c - e, o_frame_start, es);
      end
      if (es) void'(q_fs.pop_front());
      if (stop_mode && !stopped && o_sclk_fall && o_bit_idx == 5'd3 && !o_ws) begin
        i_stop = 1'b1;
        stopped = 1'b1;
      end
      if (stop_mode && c == t_exit - 1) begin
        n_vec++;
        if (o_busy !== 1'b1) begin
          n_bad++;
          $display("FAIL %s busy_before_exit: got %b want 1", name, o_busy);
        end
      end
      if (stop_mode && (c == t_exit || c == t_exit + 5)) begin
        n_vec++;
        if (o_busy !== 1'b0 || o_ws !== 1'b1 || o_sclk !== 1'b0 || o_bit_idx !== 5'd0 || u_if.cfg_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL %s idle_after_drain @+%0d: busy=%b ws=%b sclk=%b idx=%0d rdy=%b want 0 1 0 0 1",
                   name, c - e, o_busy, o_ws, o_sclk, o_bit_idx, u_if.cfg_ready);
        end
      end
    end
    n_vec++;
    if (q_rise.size() + q_fall.size() + q_wsc.size() + q_fs.size() != 0 || (stop_mode && !stopped)) begin
      n_bad++;
      $display("FAIL %s leftover: %0d expected strobes never seen, stop_issued=%b",
               name, q_rise.size() + q_fall.size() + q_wsc.size() + q_fs.size(), stopped);
    end
    $display("%s: half=%0d W=%0d cycles=%0d stop=%b done", name, h, w, len, stop_mode);
    if (!stop_mode) do_reset();
  endtask

  task automatic test_reset();
    load_cfg(2, f16bits);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 37; k++) tick();
    #2;
    rst_ = 1'b0;
    #1;
    n_vec++;
    if (o_sclk !== 1'b0 || o_ws !== 1'b1 || o_busy !== 1'b0 || u_if.cfg_ready !== 1'b1 || o_bit_idx !== 5'd0) begin
      n_bad++;
      $display("FAIL async_reset: sclk=%b ws=%b busy=%b rdy=%b idx=%0d want 0 1 0 1 0",
               o_sclk, o_ws, o_busy, u_if.cfg_ready, o_bit_idx);
    end
    tick();
    rst_ = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_vec++;
    if (o_cfg_err !== 1'b1 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_clears_cfg: err=%b busy=%b want 1 0", o_cfg_err, o_busy);
    end
    $display("async_reset: sclk=%b ws=%b busy=%b", o_sclk, o_ws, o_busy);
    do_reset();
  endtask

  task automatic test_cfg_errors();
    u_if.cfg_valid = 1'b1;
    u_if.cfg_half = 6'd0;
    tick();
    u_if.cfg_valid = 1'b0;
    n_vec++;
    if (o_cfg_err !== 1'b1) begin
      n_bad++;
      $display("FAIL half0_err: got %b want 1", o_cfg_err);
    end
    tick();
    n_vec++;
    if (o_cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pulse_width: got %b want 0", o_cfg_err);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_vec++;
    if (o_cfg_err !== 1'b1 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_no_cfg: err=%b busy=%b want 1 0", o_cfg_err, o_busy);
    end
    load_cfg(2, f16bits);
    n_vec++;
    if (o_cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL good_cfg_err: got %b want 0", o_cfg_err);
    end
    load_cfg(0, f32bits);
    n_vec++;
    if (o_cfg_err !== 1'b1) begin
      n_bad++;
      $display("FAIL half0_after_load: got %b want 1", o_cfg_err);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL start_keeps_cfg: busy=%b want 1", o_busy);
    end
    tick();
    tick();
    n_vec++;
    if (o_sclk_rise !== 1'b1) begin
      n_bad++;
      $display("FAIL old_half_kept: rise=%b want 1 at entry+2", o_sclk_rise);
    end
    $display("cfg_errors: checked");
    do_reset();
  endtask

  task automatic test_collisions();
    int e, nr, first;
    load_cfg(1, f16bits);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    u_if.cfg_valid = 1'b1;
    u_if.cfg_half = 6'd5;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (u_if.cfg_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL ready_in_run: got %b want 0", u_if.cfg_ready);
      end
    end
    u_if.cfg_valid = 1'b0;
    nr = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_sclk_rise) nr++;
    end
    n_vec++;
    if (nr !== 5) begin
      n_bad++;
      $display("FAIL cfg_ignored_in_run: rises=%0d want 5", nr);
    end
    do_reset();
    load_cfg(1, f16bits);
    u_if.cfg_valid = 1'b1;
    u_if.cfg_half = 6'd3;
    i_start = 1'b1;
    tick();
    u_if.cfg_valid = 1'b0;
    i_start = 1'b0;
    e = cyc;
    n_vec++;
    if (o_busy !== 1'b1 || o_cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_start_same_cycle: busy=%b err=%b want 1 0", o_busy, o_cfg_err);
    end
    first = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_sclk_rise) begin
        first = cyc - e;
        break;
      end
    end
    n_vec++;
    if (first !== 3) begin
      n_bad++;
      $display("FAIL new_half_used: first rise at +%0d want +3", first);
    end
    do_reset();
    load_cfg(1, f16bits);
    i_start = 1'b1;
    i_stop = 1'b1;
    tick();
    i_start = 1'b0;
    i_stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (o_busy !== 1'b0 || o_sclk !== 1'b0) begin
        n_bad++;
        $display("FAIL start_stop_idle: busy=%b sclk=%b want 0 0", o_busy, o_sclk);
      end
      tick();
    end
    $display("collisions: checked");
    do_reset();
  endtask

  initial begin
    u_if.cfg_valid = 1'b0;
    u_if.cfg_half = 6'd0;
    u_if.cfg_frame = f16bits;
    #2;
    rst_ = 1'b0;
    tick();
    tick();
    test_reset_values();
    rst_ = 1'b1;
    tick();
    test_cfg_errors();
    test_stream("half2_f16", 2, f16bits, 300, 1'b0);
    test_stream("half3_f32", 3, f32bits, 400, 1'b0);
    test_stream("stop_drain", 1, f16bits, 80, 1'b1);
    test_reset();
    test_collisions();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
